riscv_cache_writebuffer: RTL and testbench
==========================================

Name: riscv_cache_writebuffer

Overview:
- Receives the per-cycle store stream produced by the cache address-setup stage: write enable, set index, way, data and byte enables.
- Buffers up to DEPTH stores and retires them into the cache data memory whenever the data-memory write port is granted.
- Coalesces back-to-back stores to the same word.
- Forwards pending store bytes to the hit stage, so loads observe stores not yet written to memory.

Parameters:
XLEN, 32, data/address width; must be a multiple of 8
SIZE, 64, cache size in KBytes; used only for IDX_BITS derivation
BLOCK_SIZE, XLEN, cache block size in bits
WAYS, 2, associativity
DEPTH, 2, buffer entries; power of 2, 1 to 8
(derived) IDX_BITS, from SETS = no_of_sets(SIZE,BLOCK_SIZE,WAYS) via no_of_index_bits(SETS)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
clear_i  in  1  discard all pending entries (cache invalidate)
wr_req_i  in  1  store valid this cycle
wr_idx_i  in  IDX_BITS  store set index
wr_way_i  in  WAYS  store way, one-hot
wr_data_i  in  XLEN  store data
wr_be_i  in  XLEN/8  store byte enables
wr_ready_o  out  1  buffer can accept a store
mem_we_o  out  1  head entry valid; write request to data memory
mem_idx_o  out  IDX_BITS  head index
mem_way_o  out  WAYS  head way
mem_data_o  out  XLEN  head data
mem_be_o  out  XLEN/8  head byte enables
mem_gnt_i  in  1  data-memory write port granted this cycle
fwd_idx_i  in  IDX_BITS  lookup index
fwd_way_i  in  WAYS  lookup way, one-hot
fwd_hit_o  out  1  at least one matching valid entry
fwd_data_o  out  XLEN  merged forwarded bytes; newest entry wins per byte
fwd_be_o  out  XLEN/8  OR of byte enables of all matching entries
empty_o  out  1  no valid entries

Behaviour:
- Circular FIFO: DEPTH entries, each holding valid, idx, way, data, be.
  - Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
- Reset (rst_i=1 at clock edge): all valid bits cleared, pointers 0, count 0.
  - After reset: empty_o=1, wr_ready_o=1, mem_we_o=0, fwd_hit_o=0.
  - mem_* and fwd_* data fields are don't-care while their qualifiers are low.
- clear_i:
  - Same effect as reset; the store presented in that cycle is also dropped.
  - rst_i takes priority over clear_i.
- wr_ready_o = (count != DEPTH). It is combinational from state only and does not depend on mem_gnt_i.
- Accept: wr_req_i & wr_ready_o. If wr_req_i=1 while not ready, the store is dropped; the upstream stage must stall.
- Coalescing (accepted store, count>0):
  - Applies when the store matches the newest entry's idx and way, and the newest entry is not being popped this cycle (i.e. not head with mem_gnt_i=1).
  - Merge per byte: data[b] taken from wr_data_i where wr_be_i[b]=1; be |= wr_be_i; count unchanged.
  - Otherwise the store is pushed at tail; tail+1, count+1.
- Drain:
  - mem_we_o = !empty_o; mem_* show head fields combinationally.
  - Pop when mem_we_o & mem_gnt_i: head valid cleared, head+1, count-1.
- Simultaneous push and pop: count unchanged; both pointers advance. When full, wr_ready_o stays 0 that cycle regardless.
- Single-entry case (DEPTH=1 or count=1) with a pop: the new store is pushed, never coalesced.
- Forwarding:
  - Purely combinational over all valid entries, including the head in its pop cycle.
  - Match = valid & idx==fwd_idx_i & way==fwd_way_i.
  - Per byte, take data from the youngest matching entry with be[b]=1.
  - fwd_data_o bytes not covered by fwd_be_o are 0.
  - The incoming store of the current cycle is NOT forwarded.
- Latency:
  - A store accepted in cycle N appears on mem_we_o in cycle N+1 at the earliest, and is forwardable from N+1.
- Data write is ordered: entries retire strictly in acceptance order.

Test Plan:
- Reset, then idle with mem_gnt_i=0 -> empty_o=1, wr_ready_o=1, mem_we_o=0, fwd_hit_o=0.
- Store idx=5, way=01, data=0x11223344, be=1111 with gnt=0; next cycle -> mem_we_o=1, mem_idx_o=5, mem_be_o=1111. Lookup idx 5 way 01 -> fwd_hit_o=1, fwd_data_o=0x11223344.
- DEPTH=2, gnt=0: stores to idx 1 and idx 2 -> wr_ready_o=0. A third store to idx 3 is dropped. gnt=1 for 2 cycles -> retires idx 1 then idx 2, then empty_o=1.
- Coalescing, gnt=0: store idx 7 be=0011 data=0x0000AABB, then idx 7 be=1100 data=0xCCDD0000 -> single entry, mem_be_o=1111, mem_data_o=0xCCDDAABB, count=1.
- Forward merge across entries: idx 4 be=1111 data=0x01020304 pushed, then idx 9, then idx 4 be=0001 data=0x000000FF (not coalesced, since newest is idx 9) -> lookup idx 4 gives fwd_data_o=0x010203FF, fwd_be_o=1111.
- Full buffer, gnt=1 and wr_req=1 in the same cycle -> the store is dropped (wr_ready_o=0). Next cycle count=DEPTH-1 and wr_ready_o=1. Asserting clear_i mid-drain -> empty_o=1 on the next cycle, no further mem_we_o.

Source files
------------

// File: rtl/riscv_cache_writebuffer.sv
// Cache store write buffer. Holds pending stores from the address-setup stage,
// coalesces back-to-back stores to the same word, drains them in order into
// the data memory and forwards pending bytes to the hit stage.
module riscv_cache_writebuffer #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SIZE       = 64,
    parameter int unsigned BLOCK_SIZE = XLEN,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned SETS      = (SIZE * 1024 * 8) / (BLOCK_SIZE * WAYS),
    localparam int unsigned IDX_BITS  = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int unsigned BE_W      = XLEN / 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                wr_req_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic [WAYS-1:0]     wr_way_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic [BE_W-1:0]     wr_be_i,
    output logic                wr_ready_o,
    output logic                mem_we_o,
    output logic [IDX_BITS-1:0] mem_idx_o,
    output logic [WAYS-1:0]     mem_way_o,
    output logic [XLEN-1:0]     mem_data_o,
    output logic [BE_W-1:0]     mem_be_o,
    input  logic                mem_gnt_i,
    input  logic [IDX_BITS-1:0] fwd_idx_i,
    input  logic [WAYS-1:0]     fwd_way_i,
    output logic                fwd_hit_o,
    output logic [XLEN-1:0]     fwd_data_o,
    output logic [BE_W-1:0]     fwd_be_o,
    output logic                empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                valid_q [DEPTH];
    logic [IDX_BITS-1:0] idx_q   [DEPTH];
    logic [WAYS-1:0]     way_q   [DEPTH];
    logic [XLEN-1:0]     data_q  [DEPTH];
    logic [BE_W-1:0]     be_q    [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [PTR_W-1:0] newest;
    logic             accept;
    logic             pop;
    logic             coalesce;
    logic             push;
    logic [XLEN-1:0]  merged_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake, drain view and coalescing decision
    always_comb begin
        empty_o    = (count_q == '0);
        wr_ready_o = (count_q != CNT_W'(DEPTH));
        mem_we_o   = !empty_o;
        mem_idx_o  = idx_q[head_q];
        mem_way_o  = way_q[head_q];
        mem_data_o = data_q[head_q];
        mem_be_o   = be_q[head_q];

        newest   = (tail_q == '0) ? PTR_W'(DEPTH - 1) : tail_q - PTR_W'(1);
        accept   = wr_req_i && wr_ready_o;
        pop      = mem_we_o && mem_gnt_i;
        // Newest entry may not be merged into while it is leaving the buffer
        coalesce = accept && !empty_o
                   && (idx_q[newest] == wr_idx_i) && (way_q[newest] == wr_way_i)
                   && !(pop && (newest == head_q));
        push     = accept && !coalesce;

        merged_data = data_q[newest];
        for (int b = 0; b < int'(BE_W); b++) begin
            if (wr_be_i[b]) merged_data[b*8 +: 8] = wr_data_i[b*8 +: 8];
        end
    end

    // Store-to-load forwarding: walk oldest to youngest so younger bytes win
    always_comb begin
        logic [PTR_W-1:0] e;
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_be_o   = '0;
        e          = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            e = PTR_W'((int'(head_q) + k) % int'(DEPTH));
            if (valid_q[e] && (idx_q[e] == fwd_idx_i) && (way_q[e] == fwd_way_i)) begin
                fwd_hit_o = 1'b1;
                fwd_be_o  = fwd_be_o | be_q[e];
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (be_q[e][b]) fwd_data_o[b*8 +: 8] = data_q[e][b*8 +: 8];
                end
            end
        end
    end

    // Control state: valid bits, pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < int'(DEPTH); i++) valid_q[i] <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry payload: written on push, merged on coalesce
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i) begin
            if (push) begin
                idx_q[tail_q]  <= wr_idx_i;
                way_q[tail_q]  <= wr_way_i;
                data_q[tail_q] <= wr_data_i;
                be_q[tail_q]   <= wr_be_i;
            end else if (coalesce) begin
                data_q[newest] <= merged_data;
                be_q[newest]   <= be_q[newest] | wr_be_i;
            end
        end
    end

endmodule

// File: tb/tb_riscv_cache_writebuffer.sv
// Directed test for the cache write buffer: a DEPTH=2 instance and a DEPTH=4
// instance share all inputs; each check targets one of them.
module tb_riscv_cache_writebuffer;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IDXW = 13;
    localparam int unsigned BEW  = 4;

    logic            clk_i = 1'b0;
    logic            rst_i, clear_i, wr_req_i, mem_gnt_i;
    logic [IDXW-1:0] wr_idx_i, fwd_idx_i;
    logic [1:0]      wr_way_i, fwd_way_i;
    logic [XLEN-1:0] wr_data_i;
    logic [BEW-1:0]  wr_be_i;

    logic            rdy2, we2, hit2, emp2;
    logic [IDXW-1:0] midx2;
    logic [1:0]      mway2;
    logic [XLEN-1:0] mdata2, fdata2;
    logic [BEW-1:0]  mbe2, fbe2;

    logic            rdy4, we4, hit4, emp4;
    logic [IDXW-1:0] midx4;
    logic [1:0]      mway4;
    logic [XLEN-1:0] mdata4, fdata4;
    logic [BEW-1:0]  mbe4, fbe4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    riscv_cache_writebuffer #(.DEPTH(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .wr_req_i(wr_req_i), .wr_idx_i(wr_idx_i), .wr_way_i(wr_way_i),
        .wr_data_i(wr_data_i), .wr_be_i(wr_be_i), .wr_ready_o(rdy2),
        .mem_we_o(we2), .mem_idx_o(midx2), .mem_way_o(mway2),
        .mem_data_o(mdata2), .mem_be_o(mbe2), .mem_gnt_i(mem_gnt_i),
        .fwd_idx_i(fwd_idx_i), .fwd_way_i(fwd_way_i), .fwd_hit_o(hit2),
        .fwd_data_o(fdata2), .fwd_be_o(fbe2), .empty_o(emp2)
    );

    riscv_cache_writebuffer #(.DEPTH(4)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .wr_req_i(wr_req_i), .wr_idx_i(wr_idx_i), .wr_way_i(wr_way_i),
        .wr_data_i(wr_data_i), .wr_be_i(wr_be_i), .wr_ready_o(rdy4),
        .mem_we_o(we4), .mem_idx_o(midx4), .mem_way_o(mway4),
        .mem_data_o(mdata4), .mem_be_o(mbe4), .mem_gnt_i(mem_gnt_i),
        .fwd_idx_i(fwd_idx_i), .fwd_way_i(fwd_way_i), .fwd_hit_o(hit4),
        .fwd_data_o(fdata4), .fwd_be_o(fbe4), .empty_o(emp4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs may be changed right after and settle by #1
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i   = 1'b0;
        wr_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        wr_idx_i  = '0;
        wr_way_i  = 2'b01;
        wr_data_i = '0;
        wr_be_i   = '0;
    endtask

    task automatic store(input int idx, input logic [XLEN-1:0] data, input logic [BEW-1:0] be);
        wr_req_i  = 1'b1;
        wr_idx_i  = IDXW'(idx);
        wr_way_i  = 2'b01;
        wr_data_i = data;
        wr_be_i   = be;
        tick();
        wr_req_i  = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_i     = 1'b1;
        fwd_idx_i = '0;
        fwd_way_i = 2'b01;
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Reset / idle state
        check("rst_empty", 64'(emp2), 64'd1);
        check("rst_ready", 64'(rdy2), 64'd1);
        check("rst_we",    64'(we2),  64'd0);
        check("rst_hit",   64'(hit2), 64'd0);

        // Single store: not forwarded in its own cycle, visible next cycle
        wr_req_i  = 1'b1; wr_idx_i = 13'd5; wr_way_i = 2'b01;
        wr_data_i = 32'h11223344; wr_be_i = 4'b1111;
        fwd_idx_i = 13'd5; fwd_way_i = 2'b01;
        #1;
        check("same_cycle_no_fwd", 64'(hit2), 64'd0);
        tick();
        wr_req_i = 1'b0;
        #1;
        check("st_we",      64'(we2),    64'd1);
        check("st_idx",     64'(midx2),  64'd5);
        check("st_be",      64'(mbe2),   64'hF);
        check("st_data",    64'(mdata2), 64'h11223344);
        check("st_hit",     64'(hit2),   64'd1);
        check("st_fwdata",  64'(fdata2), 64'h11223344);
        check("st_fwbe",    64'(fbe2),   64'hF);
        fwd_way_i = 2'b10;
        #1;
        check("st_wrong_way_miss", 64'(hit2), 64'd0);
        fwd_way_i = 2'b01;
        do_clear();
        check("clr_empty", 64'(emp2), 64'd1);

        // Fill DEPTH=2, overflow store dropped, ordered drain
        store(1, 32'hA1A1A1A1, 4'hF);
        store(2, 32'hA2A2A2A2, 4'hF);
        #1;
        check("full_ready2", 64'(rdy2), 64'd0);
        check("full_ready4", 64'(rdy4), 64'd1);
        store(3, 32'hA3A3A3A3, 4'hF);
        mem_gnt_i = 1'b1;
        #1;
        check("drain_first", 64'(midx2), 64'd1);
        tick();
        check("drain_second", 64'(midx2), 64'd2);
        check("drain_second_data", 64'(mdata2), 64'hA2A2A2A2);
        tick();
        mem_gnt_i = 1'b0;
        #1;
        check("drain_empty", 64'(emp2), 64'd1);
        check("drain_we",    64'(we2),  64'd0);
        do_clear();

        // Coalescing two halves of one word
        store(7, 32'h0000AABB, 4'b0011);
        store(7, 32'hCCDD0000, 4'b1100);
        #1;
        check("coal_be",    64'(mbe2),   64'hF);
        check("coal_data",  64'(mdata2), 64'hCCDDAABB);
        check("coal_ready", 64'(rdy2),   64'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        #1;
        check("coal_single_entry", 64'(emp2), 64'd1);
        do_clear();

        // Forward merge across entries (DEPTH=4 holds all three)
        store(4, 32'h01020304, 4'hF);
        store(9, 32'h99999999, 4'hF);
        store(4, 32'h000000FF, 4'b0001);
        fwd_idx_i = 13'd4;
        #1;
        check("fwd4_hit",  64'(hit4),   64'd1);
        check("fwd4_data", 64'(fdata4), 64'h010203FF);
        check("fwd4_be",   64'(fbe4),   64'hF);
        check("fwd2_data_dropped", 64'(fdata2), 64'h01020304);
        fwd_idx_i = 13'd9;
        #1;
        check("fwd4_idx9", 64'(fdata4), 64'h99999999);
        do_clear();

        // Single entry being popped: new store to same word is pushed, not merged
        store(6, 32'h11111111, 4'hF);
        wr_req_i = 1'b1; wr_idx_i = 13'd6; wr_data_i = 32'h00000022; wr_be_i = 4'b0001;
        mem_gnt_i = 1'b1;
        tick();
        wr_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        check("popmerge_we",   64'(we2),          64'd1);
        check("popmerge_be",   64'(mbe2),         64'h1);
        check("popmerge_byte", 64'(mdata2[7:0]),  64'h22);
        do_clear();

        // Full with simultaneous grant and request: store dropped
        store(1, 32'hB1B1B1B1, 4'hF);
        store(2, 32'hB2B2B2B2, 4'hF);
        wr_req_i = 1'b1; wr_idx_i = 13'd3; wr_data_i = 32'hB3B3B3B3; wr_be_i = 4'hF;
        mem_gnt_i = 1'b1;
        #1;
        check("fullgnt_ready", 64'(rdy2), 64'd0);
        tick();
        wr_req_i = 1'b0; mem_gnt_i = 1'b0;
        fwd_idx_i = 13'd3;
        #1;
        check("fullgnt_ready_after", 64'(rdy2),  64'd1);
        check("fullgnt_head",        64'(midx2), 64'd2);
        check("fullgnt_dropped",     64'(hit2),  64'd0);

        // Clear mid-drain
        mem_gnt_i = 1'b1;
        clear_i   = 1'b1;
        tick();
        clear_i = 1'b0;
        #1;
        check("middrain_empty", 64'(emp2), 64'd1);
        check("middrain_we",    64'(we2),  64'd0);
        tick();
        check("middrain_we_later", 64'(we2), 64'd0);
        mem_gnt_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
